// File: rtl/res_packer.sv
// ============================================================================
// Module  : res_packer
// Brief   : Packs RES_WIDTH MAC results into DATA_WIDTH AXI-Stream words in
//           bursts. Optional stall counter: define RES_PACKER_STALL_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module res_packer #(
   parameter int DATA_WIDTH   = 64,
   parameter int RES_WIDTH    = 16,
   parameter int BURST_LENGTH = 15
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic [31:0]               nburst,
   input  logic [RES_WIDTH-1:0]      res_data,
   input  logic                      res_valid,
   output logic                      res_ready,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic                      idle,
   output logic                      done
`ifdef RES_PACKER_STALL_CNT_EN
   ,output logic [31:0]              stall_cnt
`endif
);

   localparam int LANES  = DATA_WIDTH / RES_WIDTH;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PACK_W = (LANES - 1) * RES_WIDTH;
   localparam int BEAT_W = (BURST_LENGTH > 0) ? $clog2(BURST_LENGTH + 1) : 1;

   localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BURST_LENGTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PACK  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [31:0]             nburst_q, nburst_d;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [PACK_W-1:0]       pack_q, pack_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [31:0]             burst_q, burst_d;
   logic                    done_q, done_d;

   logic w_out_pop;
   logic w_accept;

   assign w_out_pop = valid_q && m_axis_tready;
   // The completing lane needs the output register free (or emptying this cycle).
   assign res_ready = (state_q == ST_PACK) &&
                      !((lane_q == C_LAST_LANE) && valid_q && !m_axis_tready);
   assign w_accept  = res_valid && res_ready;

   always_comb begin
      state_d  = state_q;
      nburst_d = nburst_q;
      lane_d   = lane_q;
      pack_d   = pack_q;
      data_d   = data_q;
      valid_d  = valid_q;
      last_d   = last_q;
      beat_d   = beat_q;
      burst_d  = burst_q;
      done_d   = 1'b0;

      if (w_out_pop) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               nburst_d = nburst;
               lane_d   = '0;
               pack_d   = '0;
               beat_d   = '0;
               burst_d  = '0;
               if (nburst == 32'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_PACK;
               end
            end
         end
         ST_PACK: begin
            if (w_accept) begin
               if (lane_q == C_LAST_LANE) begin
                  data_d  = {res_data, pack_q};
                  valid_d = 1'b1;
                  last_d  = (beat_q == C_LAST_BEAT);
                  lane_d  = '0;
                  pack_d  = '0;
                  if (beat_q == C_LAST_BEAT) begin
                     beat_d  = '0;
                     burst_d = burst_q + 32'd1;
                     if (burst_q == nburst_q - 32'd1) begin
                        state_d = ST_DRAIN;
                     end
                  end else begin
                     beat_d = beat_q + BEAT_W'(1);
                  end
               end else begin
                  for (int k = 0; k < LANES - 1; k++) begin
                     if (lane_q == LANE_W'(k)) begin
                        pack_d[k*RES_WIDTH +: RES_WIDTH] = res_data;
                     end
                  end
                  lane_d = lane_q + LANE_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Only the final word can be pending here.
            if (w_out_pop && last_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         nburst_q <= '0;
         lane_q   <= '0;
         pack_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         beat_q   <= '0;
         burst_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         nburst_q <= nburst_d;
         lane_q   <= lane_d;
         pack_q   <= pack_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         beat_q   <= beat_d;
         burst_q  <= burst_d;
         done_q   <= done_d;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tstrb  = {(DATA_WIDTH/8){valid_q}};
   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q;
   assign idle          = (state_q == ST_IDLE);
   assign done          = done_q;

`ifdef RES_PACKER_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == ST_IDLE) && start) begin
         stall_d = '0;
      end else if ((state_q != ST_IDLE) && valid_q && !m_axis_tready &&
                   (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_res_packer.sv
// ============================================================================
// Module  : tb_res_packer
// Brief   : Randomized self-checking bench for res_packer against a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_res_packer;

   logic        clk = 1'b0;
   logic        rstn, start;
   logic [31:0] nburst;
   logic [15:0] res_data;
   logic        res_valid, res_ready;
   logic [63:0] tdata;
   logic [7:0]  tstrb;
   logic        tvalid, tlast, tready, idle, done;
`ifdef RES_PACKER_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   res_packer #(.DATA_WIDTH(64), .RES_WIDTH(16), .BURST_LENGTH(15)) dut (
      .clk(clk), .rstn(rstn), .start(start), .nburst(nburst),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .m_axis_tdata(tdata), .m_axis_tstrb(tstrb), .m_axis_tvalid(tvalid),
      .m_axis_tlast(tlast), .m_axis_tready(tready), .idle(idle), .done(done)
`ifdef RES_PACKER_STALL_CNT_EN
      ,.stall_cnt(stall_cnt)
`endif
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [15:0] res_q[$];
   int          run_acc, run_total, words_out, tlast_cnt, done_cnt;
   bit          model_active, done_exp, exp_tv, prev_stall, post_rst, was_active;
   logic [63:0] prev_data, first_word, w;
   logic        prev_last;
   longint      stall_model;
   int          vmode, rmode;
   bit          seq_data;

   task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task model_clear();
      res_q.delete();
      model_active = 0; done_exp = 0; exp_tv = 0; prev_stall = 0;
      run_acc = 0; run_total = 0; words_out = 0;
   endtask

   // One clock: observe at the falling edge, then drive fresh inputs after the rising edge.
   task cycle();
      @(negedge clk);
      if (!rstn) begin
         model_clear();
         post_rst = 1;
      end else begin
         was_active = model_active;
         if (post_rst) begin
            chk("post_reset_tdata", tdata, 0);
            chk("post_reset_tlast", tlast, 0);
            post_rst = 0;
         end
         chk("idle", idle, !model_active);
         chk("done", done, done_exp);
         if (done) done_cnt++;
         if (exp_tv) chk("latency_tvalid", tvalid, 1);
         if (prev_stall) begin
            chk("stall_tvalid", tvalid, 1);
            chk("stall_tdata", tdata, prev_data);
            chk("stall_tlast", tlast, prev_last);
         end
         if (!model_active) chk("tvalid_outside_run", tvalid, 0);
         if (tvalid) chk("tstrb", tstrb, 8'hFF);
         if (!(model_active && run_acc < run_total * 4)) chk("res_ready_low", res_ready, 0);

         done_exp   = 0;
         exp_tv     = 0;
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
         if (was_active && tvalid && !tready && stall_model < 64'hFFFF_FFFF) stall_model++;

         if (res_valid && res_ready) begin
            res_q.push_back(res_data);
            run_acc++;
            chk("accept_within_limit", run_acc <= run_total * 4, 1);
            if (run_acc % 4 == 0) exp_tv = 1;
         end

         if (tvalid && tready) begin
            chk("word_available", res_q.size() >= 4, 1);
            if (res_q.size() >= 4) begin
               w = {res_q[3], res_q[2], res_q[1], res_q[0]};
               repeat (4) void'(res_q.pop_front());
               chk("tdata", tdata, w);
            end
            chk("tlast", tlast, (words_out % 16) == 15);
            if (words_out == 0) first_word = tdata;
            if (tlast) tlast_cnt++;
            words_out++;
            chk("word_within_run", words_out <= run_total, 1);
            if (words_out == run_total) begin
               model_active = 0;
               done_exp     = 1;
            end
         end

         if (start && !was_active) begin
            res_q.delete();
            run_total   = int'(nburst) * 16;
            run_acc     = 0;
            words_out   = 0;
            tlast_cnt   = 0;
            done_cnt    = 0;
            stall_model = 0;
            first_word  = 'x;
            if (nburst == 0) done_exp = 1;
            else model_active = 1;
         end
      end
      @(posedge clk);
      #1;
      res_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (rmode)
         0:       tready = 1'b1;
         1:       tready = !tready;
         default: tready = 1'($urandom_range(0, 1));
      endcase
      res_data = seq_data ? 16'(run_acc) : 16'($urandom);
   endtask

   task run(input int nb, input int vm, input int rm, input bit seq, input int extra_start_at);
      vmode = vm; rmode = rm; seq_data = seq;
      nburst = nb;
      start  = 1;
      cycle();
      start  = 0;
      for (int i = 0; i < 20000 && model_active; i++) begin
         if (i == extra_start_at) begin
            start  = 1;
            nburst = 7;
         end
         cycle();
         start = 0;
      end
      chk("run_timeout", model_active, 0);
      repeat (2) cycle();
      chk("words_total", words_out, nb * 16);
      chk("tlast_count", tlast_cnt, nb);
      chk("done_count", done_cnt, 1);
      chk("accepted_total", run_acc, nb * 64);
      if (seq && nb > 0) chk("word0", first_word, 64'h0003_0002_0001_0000);
`ifdef RES_PACKER_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, stall_model);
`endif
   endtask

   initial begin
      rstn = 0; start = 0; nburst = 0; res_valid = 0; res_data = 0; tready = 1;
      vmode = 0; rmode = 0; seq_data = 1; post_rst = 0; stall_model = 0;
      tlast_cnt = 0; done_cnt = 0; first_word = 'x;
      model_clear();
      repeat (3) cycle();
      chk("reset_idle", idle, 1);
      chk("reset_res_ready", res_ready, 0);
      chk("reset_tvalid", tvalid, 0);
      chk("reset_tlast", tlast, 0);
      chk("reset_tdata", tdata, 0);
      chk("reset_done", done, 0);
      rstn = 1;

      // Sequential 0..63, full throughput, res_valid held after the last result.
      run(1, 0, 0, 1, -1);
      // Output stalls every other cycle over two bursts.
      run(2, 0, 1, 0, -1);
`ifdef RES_PACKER_STALL_CNT_EN
      chk("stall_cnt_nonzero", stall_cnt != 0, 1);
`endif
      // Empty run.
      run(0, 0, 0, 0, -1);
      // Random traffic with a stray start mid-run.
      run(3, 1, 2, 0, 20);

      // Reset after six results, then a fresh run.
      vmode = 0; rmode = 0; seq_data = 1;
      nburst = 2; start = 1;
      cycle();
      start = 0;
      for (int i = 0; i < 100 && run_acc < 6; i++) cycle();
      chk("six_accepted", run_acc >= 6, 1);
      rstn = 0;
      cycle();
      rstn = 1;
      chk("mid_reset_tvalid", tvalid, 0);
      chk("mid_reset_idle", idle, 1);
      chk("mid_reset_res_ready", res_ready, 0);
      run(1, 0, 0, 1, -1);

      run(2, 1, 2, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/res_packer.md
RES_PACKER -- requirements
Module: res_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the output stream word width in bits.
REQ-002 Parameter RES_WIDTH, default 16, SHALL set the MAC result width; DATA_WIDTH/RES_WIDTH (default 4) lanes per word.
REQ-003 Parameter BURST_LENGTH, default 15, SHALL set the AXI beats per burst minus one (16 beats per burst).
REQ-004 clk  input  1  -- single clock; all logic SHALL be rising-edge.
REQ-005 rstn  input  1  -- reset, synchronous, active-low.
REQ-006 start  input  1  -- single-cycle run request (WSTART_REG edge).
REQ-007 nburst  input  32  -- bursts per run, sampled on accepted start.
REQ-008 res_data  input  RES_WIDTH  -- MAC result.
REQ-009 res_valid  input  1  -- res_data valid.
REQ-010 res_ready  output  1  -- packer accepts res_data this cycle.
REQ-011 m_axis_tdata  output  DATA_WIDTH  -- packed word to the axi_mst write path.
REQ-012 m_axis_tstrb  output  DATA_WIDTH/8  -- byte strobes.
REQ-013 m_axis_tvalid, m_axis_tlast  output  1 each  -- AXIS valid, end of burst.
REQ-014 m_axis_tready  input  1  -- AXIS ready.
REQ-015 idle  output  1  -- high when in IDLE.
REQ-016 done  output  1  -- one-cycle pulse at run completion.

Function
REQ-017 States SHALL be IDLE, PACK, DRAIN; IDLE->PACK on start with nburst!=0; IDLE->IDLE with done pulse next cycle on start with nburst==0.
REQ-018 start outside IDLE SHALL be ignored; nburst SHALL be sampled only on accepted start.
REQ-019 A result SHALL transfer when res_valid && res_ready; lane k of a word (k=0..3) SHALL hold the k-th transferred result at bits [16k+15:16k].
REQ-020 res_ready SHALL be high only in PACK, and low when the pack register holds 3 lanes and the output register is full and not being consumed this cycle.
REQ-021 The 4th lane SHALL complete the word, which moves to the output register in the same edge; the pack register SHALL restart at lane 0 with zero bubble cycles.
REQ-022 The output register SHALL hold tdata/tlast stable while tvalid && !tready; tvalid SHALL not drop without a handshake.
REQ-023 m_axis_tstrb SHALL be all ones whenever tvalid is high.
REQ-024 A 4-bit beat counter SHALL count transferred words; tlast SHALL be high on beat BURST_LENGTH, after which the counter wraps to 0 and a 32-bit burst counter increments.
REQ-025 After the last word of burst nburst-1 is produced, the state SHALL go to DRAIN and res_ready SHALL stay low.
REQ-026 In DRAIN, on the handshake of the final tlast word the state SHALL go to IDLE, with done high for exactly the following cycle.
REQ-027 Total words per run SHALL equal nburst*(BURST_LENGTH+1); results beyond that SHALL not be accepted.
REQ-028 Latency: from the 4th lane accepted to tvalid high SHALL be 1 cycle.

Reset
REQ-029 While rstn==0 at a clock edge, outputs SHALL be: res_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, idle=1, done=0, state IDLE.
REQ-030 While rstn==0 at a clock edge, all counters and lanes SHALL be cleared.
REQ-031 Reset mid-run SHALL discard partial and pending words without emitting them.

Configuration
REQ-032 With macro RES_PACKER_STALL_CNT_EN defined, output stall_cnt[31:0] SHALL count cycles with tvalid && !tready during a run.
REQ-033 With RES_PACKER_STALL_CNT_EN defined, stall_cnt SHALL clear on accepted start and on reset, and saturate at 32'hFFFFFFFF.
REQ-034 Without RES_PACKER_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent and all other behaviour identical.

Verification
REQ-035 nburst=1, res_valid=1 with results 0..63, tready=1 -> 16 words; word0=64'h0003_0002_0001_0000; tlast only on word 15; done pulses once.
REQ-036 nburst=2, tready toggled 1/0 each cycle -> 32 words in order, tdata stable during stalls; tlast on words 15 and 31; stall_cnt>0 if enabled.
REQ-037 start with nburst=0 -> no tvalid; done high 1 cycle later; idle stays 1.
REQ-038 Second start pulse during a nburst=3 run -> ignored; exactly 48 words emitted.
REQ-039 rstn=0 for one cycle after 6 results accepted -> tvalid=0, idle=1; a new nburst=1 run restarts at lane 0 with word0 from new data.
REQ-040 res_valid held 1 after the 64th result of a nburst=1 run -> res_ready=0 from then; no 65th result accepted.
